alarm_minigame: RTL and testbench

- Wake-up minigame; sits directly downstream of the alarm ringer.
- Started by the ringer's minigame_enable level.
- Shows a random target key on LEDs; user must hit ROUNDS correct keys in a row, each within a timeout.
- On success pulses minigame_done, which the ringer uses to drop minigame_enable.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_minigame_lfsr8.sv | 20 ++
 rtl/alarm_minigame.sv | 144 ++++++++++++++
 tb/tb_alarm_minigame.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm wake-up minigame.
package alarm_pkg;

    localparam int LFSR_W = 8;
    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (state bits 7, 5, 4, 3)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam int NUM_KEYS = 4;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WAIT,
        FAIL,
        DONE
    } state_t;

    // The two low LFSR bits choose which key LED lights up.
    function automatic logic [NUM_KEYS-1:0] key_from_lfsr(input logic [LFSR_W-1:0] s);
        return NUM_KEYS'(1) << s[1:0];
    endfunction

endpackage

// File: rtl/alarm_minigame_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick minigame targets.
module lfsr8
    import alarm_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
)(
    input  logic              MCLK,
    input  logic              RESET,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state <= SEED;
        end else begin
            state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/alarm_minigame.sv
// Wake-up minigame: press ROUNDS random target keys in a row, each before a timeout.
// Optional saturating fail counter output enabled by ALARM_MINIGAME_FAILCNT_EN.
module alarm_minigame
    import alarm_pkg::*;
#(
    parameter int unsigned       ROUNDS        = 4,
    parameter int unsigned       TICK_DIV      = 50000,
    parameter int unsigned       TIMEOUT_TICKS = 200,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
)(
    input  logic                MCLK,
    input  logic                RESET,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] target,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                fail_pulse,
    output logic                minigame_done
`ifdef ALARM_MINIGAME_FAILCNT_EN
    ,
    output logic [7:0]          fail_count
`endif
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]       ROUNDS_V = 4'(ROUNDS);

    state_t             state;
    logic               enable_d;
    logic [DIV_W-1:0]   div_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [LFSR_W-1:0]  lfsr_state;
    logic               start;
    logic               hit;
    logic               miss;
    logic               timeout;
    logic [3:0]         round_next;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .MCLK  (MCLK),
        .RESET (RESET),
        .state (lfsr_state)
    );

    assign start      = enable & ~enable_d;
    assign hit        = (key == target);
    assign miss       = (key != '0) & ~hit;
    // Fires on the edge where the last divider wrap would bring the tick count to TIMEOUT_TICKS
    assign timeout    = (div_cnt == DIV_LAST) && (tmo_cnt == TMO_LAST);
    assign round_next = round_idx + 4'd1;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            enable_d      <= 1'b0;
            div_cnt       <= '0;
            tmo_cnt       <= '0;
            target        <= '0;
            round_idx     <= '0;
            busy          <= 1'b0;
            fail_pulse    <= 1'b0;
            minigame_done <= 1'b0;
`ifdef ALARM_MINIGAME_FAILCNT_EN
            fail_count    <= '0;
`endif
        end else begin
            enable_d <= enable;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= GEN;
                        round_idx <= '0;
                        busy      <= 1'b1;
`ifdef ALARM_MINIGAME_FAILCNT_EN
                        fail_count <= '0;
`endif
                    end
                end
                GEN: begin
                    state   <= WAIT;
                    target  <= key_from_lfsr(lfsr_state);
                    div_cnt <= '0;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    // Abort beats a correct key, which beats a wrong key or the timeout
                    if (!enable) begin
                        state     <= IDLE;
                        target    <= '0;
                        round_idx <= '0;
                        busy      <= 1'b0;
                    end else if (hit) begin
                        target    <= '0;
                        round_idx <= round_next;
                        if (round_next == ROUNDS_V) begin
                            state         <= DONE;
                            minigame_done <= 1'b1;
                        end else begin
                            state <= GEN;
                        end
                    end else if (miss || timeout) begin
                        state      <= FAIL;
                        fail_pulse <= 1'b1;
                        target     <= '0;
                        round_idx  <= '0;
`ifdef ALARM_MINIGAME_FAILCNT_EN
                        if (fail_count != 8'hFF) begin
                            fail_count <= fail_count + 8'd1;
                        end
`endif
                    end
                end
                FAIL: begin
                    fail_pulse <= 1'b0;
                    if (enable) begin
                        state <= GEN;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    minigame_done <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_minigame.sv
// Self-checking bench for alarm_minigame with a cycle-level behavioural model.
// Define ALARM_MINIGAME_FAILCNT_EN to also exercise the fail counter.
module tb_alarm_minigame;

    localparam int ROUNDS        = 2;
    localparam int TICK_DIV      = 4;
    localparam int TIMEOUT_TICKS = 3;
    localparam logic [7:0] SEED  = 8'hA5;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] key = 4'd0;
    logic [3:0] target;
    logic [3:0] round_idx;
    logic       busy;
    logic       fail_pulse;
    logic       minigame_done;
`ifdef ALARM_MINIGAME_FAILCNT_EN
    logic [7:0] fail_count;
`endif

    int checks = 0;
    int errors = 0;

    alarm_minigame #(
        .ROUNDS        (ROUNDS),
        .TICK_DIV      (TICK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .LFSR_SEED     (SEED)
    ) dut (
        .MCLK          (MCLK),
        .RESET         (RESET),
        .enable        (enable),
        .key           (key),
        .target        (target),
        .round_idx     (round_idx),
        .busy          (busy),
        .fail_pulse    (fail_pulse),
        .minigame_done (minigame_done)
`ifdef ALARM_MINIGAME_FAILCNT_EN
        ,
        .fail_count    (fail_count)
`endif
    );

    always #5 MCLK = ~MCLK;

    // Behavioural model: tracks what the player sees, with the timeout as a
    // plain cycle count since the target appeared.
    logic [7:0] m_lfsr;
    logic       m_en_prev;
    logic [3:0] m_target;
    int         m_round;
    bit         m_busy, m_fail, m_done, m_gen, m_waiting;
    int         m_wait_cycles;
    int         m_failcnt;

    always @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            m_lfsr = SEED;
            m_en_prev = 1'b0;
            m_target = 4'd0;
            m_round = 0;
            m_busy = 0; m_fail = 0; m_done = 0; m_gen = 0; m_waiting = 0;
            m_wait_cycles = 0;
            m_failcnt = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_fail) begin
                m_fail = 0;
                if (enable) m_gen = 1;
                else m_busy = 0;
            end else if (m_gen) begin
                m_gen = 0;
                m_target = 4'b0001 << m_lfsr[1:0];
                m_waiting = 1;
                m_wait_cycles = 0;
            end else if (m_waiting) begin
                m_wait_cycles++;
                if (!enable) begin
                    m_waiting = 0; m_busy = 0; m_target = 4'd0; m_round = 0;
                end else if (key == m_target) begin
                    m_waiting = 0; m_target = 4'd0; m_round++;
                    if (m_round == ROUNDS) m_done = 1;
                    else m_gen = 1;
                end else if (key != 4'd0 || m_wait_cycles == TICK_DIV * TIMEOUT_TICKS) begin
                    m_waiting = 0; m_target = 4'd0; m_round = 0; m_fail = 1;
                    if (m_failcnt < 255) m_failcnt++;
                end
            end else if (enable && !m_en_prev) begin
                m_busy = 1; m_round = 0; m_gen = 1; m_failcnt = 0;
            end
            m_en_prev = enable;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge MCLK) begin
        if (!RESET) begin
            checkOutput("target", int'(target), int'(m_target));
            checkOutput("round_idx", int'(round_idx), m_round);
            checkOutput("busy", int'(busy), int'(m_busy));
            checkOutput("fail_pulse", int'(fail_pulse), int'(m_fail));
            checkOutput("minigame_done", int'(minigame_done), int'(m_done));
`ifdef ALARM_MINIGAME_FAILCNT_EN
            checkOutput("fail_count", int'(fail_count), m_failcnt);
`endif
        end
    end

    task automatic applyStimulus(input logic en, input logic [3:0] k);
        enable = en;
        key = k;
    endtask

    task automatic nextCycle();
        @(negedge MCLK);
        #1;
    endtask

    task automatic waitForTarget();
        int n = 0;
        while (m_target == 4'd0 && n < 40) begin
            nextCycle();
            n++;
        end
        if (m_target == 4'd0) checkOutput("wait_entry_timeout", 0, 1);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    initial begin
        int lat;
        logic [3:0] tgt;

        #2 RESET = 1'b1;
        #1;
        checkOutput("reset_target", int'(target), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_round", int'(round_idx), 0);
        nextCycle();
        nextCycle();
        RESET = 1'b0;
        applyStimulus(1'b1, 4'd0);

        // Start edge, then the first target derived from the seed's successor 8'h4A
        nextCycle();
        checkOutput("start_busy", int'(busy), 1);
        checkOutput("start_target", int'(target), 0);
        nextCycle();
        checkOutput("first_target", int'(target), 4'b0100);

        applyStimulus(1'b1, m_target);
        nextCycle();
        checkOutput("round_one", int'(round_idx), 1);
        applyStimulus(1'b1, 4'd0);
        waitForTarget();
        applyStimulus(1'b1, m_target);
        nextCycle();
        checkOutput("done_pulse", int'(minigame_done), 1);
        checkOutput("done_round", int'(round_idx), 2);
        checkOutput("done_target", int'(target), 0);
        applyStimulus(1'b1, 4'd0);
        nextCycle();
        checkOutput("done_clear", int'(minigame_done), 0);
        checkOutput("done_busy_fall", int'(busy), 0);
        repeat (3) nextCycle();
        checkOutput("no_restart_on_level", int'(busy), 0);

        // Wrong key after one correct press
        applyStimulus(1'b0, 4'd0);
        nextCycle();
        applyStimulus(1'b1, 4'd0);
        nextCycle();
        checkOutput("restart_busy", int'(busy), 1);
        waitForTarget();
        applyStimulus(1'b1, m_target);
        nextCycle();
        applyStimulus(1'b1, 4'd0);
        waitForTarget();
        applyStimulus(1'b1, rotl(m_target));
        nextCycle();
        checkOutput("wrong_fail", int'(fail_pulse), 1);
        checkOutput("wrong_round", int'(round_idx), 0);
        applyStimulus(1'b1, 4'd0);
        nextCycle();
        checkOutput("wrong_fail_once", int'(fail_pulse), 0);
        nextCycle();
        checkOutput("game_continues", int'(target != 4'd0), 1);

        // Timeout with no key
        lat = 0;
        while (lat < 20 && !fail_pulse) begin
            nextCycle();
            lat++;
        end
        checkOutput("timeout_latency", lat, TICK_DIV * TIMEOUT_TICKS);

        // Correct key on the timeout edge wins
        waitForTarget();
        repeat (TICK_DIV * TIMEOUT_TICKS - 1) nextCycle();
        applyStimulus(1'b1, m_target);
        nextCycle();
        checkOutput("edge_key_no_fail", int'(fail_pulse), 0);
        checkOutput("edge_key_round", int'(round_idx), 1);
        applyStimulus(1'b1, 4'd0);

        // Multiple bits including the target
        waitForTarget();
        tgt = m_target;
        applyStimulus(1'b1, tgt | rotl(tgt));
        nextCycle();
        checkOutput("multibit_fail", int'(fail_pulse), 1);
        checkOutput("multibit_round", int'(round_idx), 0);
        applyStimulus(1'b1, 4'd0);

`ifdef ALARM_MINIGAME_FAILCNT_EN
        applyStimulus(1'b0, 4'd0);
        nextCycle();
        applyStimulus(1'b1, 4'd0);
        nextCycle();
        checkOutput("failcnt_start_clear", int'(fail_count), 0);
        repeat (3) begin
            waitForTarget();
            applyStimulus(1'b1, rotl(m_target));
            nextCycle();
            applyStimulus(1'b1, 4'd0);
        end
        checkOutput("failcnt_three", int'(fail_count), 3);
        applyStimulus(1'b0, 4'd0);
        nextCycle();
        checkOutput("failcnt_hold_idle", int'(fail_count), 3);
        applyStimulus(1'b1, 4'd0);
        nextCycle();
        checkOutput("failcnt_cleared", int'(fail_count), 0);
`endif

        // Abort mid-WAIT with one round banked
        waitForTarget();
        applyStimulus(1'b1, m_target);
        nextCycle();
        applyStimulus(1'b1, 4'd0);
        waitForTarget();
        checkOutput("abort_pre_round", int'(round_idx), 1);
        applyStimulus(1'b0, 4'd0);
        nextCycle();
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_round", int'(round_idx), 0);
        checkOutput("abort_target", int'(target), 0);
        checkOutput("abort_fail", int'(fail_pulse), 0);
        checkOutput("abort_done", int'(minigame_done), 0);
        repeat (2) nextCycle();
        checkOutput("abort_stays_idle", int'(busy), 0);
        applyStimulus(1'b1, 4'd0);
        nextCycle();
        checkOutput("abort_restart", int'(busy), 1);

        // Asynchronous reset while waiting for a key
        waitForTarget();
        #2 RESET = 1'b1;
        #1;
        checkOutput("async_target", int'(target), 0);
        checkOutput("async_round", int'(round_idx), 0);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_fail", int'(fail_pulse), 0);
        checkOutput("async_done", int'(minigame_done), 0);
`ifdef ALARM_MINIGAME_FAILCNT_EN
        checkOutput("async_failcnt", int'(fail_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
